// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory controller: FSM states,
// sign_mask access-size codes and the alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [2:0] MASK_B   = 3'b001;
  localparam logic [2:0] MASK_H   = 3'b011;
  localparam logic [2:0] MASK_W   = 3'b111;
  localparam int         SIGN_BIT = 3;

  // Bytes are always aligned; halves need a[0]=0; anything else is treated as a word.
  function automatic logic is_aligned(input logic [1:0] lane, input logic [2:0] sz);
    case (sz)
      MASK_B:  return 1'b1;
      MASK_H:  return ~lane[0];
      default: return (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline data port plus word-wide BRAM port of the data-memory controller.
// master = pipeline/BRAM side, slave = controller.
interface data_mem_ctrl_if #(
  parameter int AW = 10
) ();
  logic [31:0]   addr;
  logic [31:0]   wr_data;
  logic          memwrite;
  logic          memread;
  logic [3:0]    sign_mask;
  logic [31:0]   rd_data;
  logic          clk_stall;
  logic          misaligned;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  modport master (
    output addr, wr_data, memwrite, memread, sign_mask, bram_dout,
    input  rd_data, clk_stall, misaligned, bram_addr, bram_we, bram_din
  );

  modport slave (
    input  addr, wr_data, memwrite, memread, sign_mask, bram_dout,
    output rd_data, clk_stall, misaligned, bram_addr, bram_we, bram_din
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/half/word out of a BRAM word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [3:0]  sign_mask,
  output logic [31:0] data
);

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] sz,
                                         input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      MASK_B:  return sgn ? 32'(b) : {24'h0, raw[7:0]};
      MASK_H:  return sgn ? 32'(h) : {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  logic [31:0] shifted;

  assign shifted = word >> {lane, 3'b000};
  assign data    = extend(shifted, sign_mask[2:0], sign_mask[SIGN_BIT]);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: IDLE -> ISSUE -> (WAIT) -> IDLE access FSM in front of a
// synchronous BRAM. Optional LED MMIO register enabled by DMEM_LED_MMIO_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus,
  output logic [7:0]     led
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
`ifdef DMEM_LED_MMIO_EN
  localparam bit LED_MMIO_EN = 1'b1;
`else
  localparam bit LED_MMIO_EN = 1'b0;
`endif

  state_e        state;
  logic          done;
  logic [AW-1:0] bram_addr_q;
  logic [31:0]   rd_data_q;

  logic [1:0]    lane_p0;
  logic [31:0]   data_p0;
  logic [3:0]    mask_p0;
  logic          store_p0;
  logic          oor_p0;
  logic          led_ld_p0;

  logic          req;
  logic          aligned_in;
  logic          in_range_in;
  logic          led_hit_in;
  logic          led_store_in;
  logic          start;
  logic [3:0]    we_lanes;
  logic [31:0]   din_lanes;
  logic [31:0]   load_word;

  assign req          = bus.memread | bus.memwrite;
  assign aligned_in   = is_aligned(bus.addr[1:0], bus.sign_mask[2:0]);
  assign in_range_in  = ({2'b00, bus.addr[31:2]} < DEPTH_LIM);
  assign led_hit_in   = LED_MMIO_EN & (bus.addr == LED_ADDR);
  assign led_store_in = led_hit_in & bus.memwrite;
  assign start        = (state == IDLE) & req & ~done & aligned_in & ~led_store_in;

  // rst masks the combinational outputs so a request held during reset stays invisible
  assign bus.clk_stall  = ~rst & ((state != IDLE) | start);
  assign bus.misaligned = ~rst & (state == IDLE) & req & ~done & ~aligned_in;
  assign bus.rd_data    = rd_data_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_din   = din_lanes;
  assign bus.bram_we    = (~rst && state == ISSUE && store_p0 && !oor_p0) ? we_lanes : 4'h0;

  always_comb begin
    we_lanes  = 4'hF;
    din_lanes = data_p0;
    case (mask_p0[2:0])
      MASK_B: begin
        we_lanes  = 4'b0001 << lane_p0;
        din_lanes = {4{data_p0[7:0]}};
      end
      MASK_H: begin
        we_lanes  = 4'b0011 << lane_p0;
        din_lanes = {2{data_p0[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_load_align u_align (
    .word      (bus.bram_dout),
    .lane      (lane_p0),
    .sign_mask (mask_p0),
    .data      (load_word)
  );

  // Stage p0: request captured on acceptance
  always_ff @(posedge clk) begin
    if (start) begin
      lane_p0   <= bus.addr[1:0];
      data_p0   <= bus.wr_data;
      mask_p0   <= bus.sign_mask;
      store_p0  <= bus.memwrite;
      oor_p0    <= ~in_range_in;
      led_ld_p0 <= led_hit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      rd_data_q   <= 32'h0;
      bram_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            done <= 1'b0;
          end else if (start) begin
            bram_addr_q <= bus.addr[AW+1:2];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (store_p0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rd_data_q <= led_ld_p0 ? {24'h0, led} : (oor_p0 ? 32'h0 : load_word);
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_LED_MMIO_EN
  logic led_wr;
  assign led_wr = (state == IDLE) & req & ~done & aligned_in & led_store_in;

  always_ff @(posedge clk) begin
    if (rst)         led <= 8'h0;
    else if (led_wr) led <= bus.wr_data[7:0];
  end
`else
  assign led = 8'h0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios followed by random traffic, checked
// against a byte-addressed reference memory model.
module tb_data_mem_ctrl;

  localparam logic [31:0] LED_ADDR  = 32'h0000_2000;
  localparam int          MEM_BYTES = 4096;
`ifdef DMEM_LED_MMIO_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] led;

  data_mem_ctrl_if #(.AW(10)) bus ();

  data_mem_ctrl #(
    .DEPTH_WORDS (1024),
    .LED_ADDR    (LED_ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM with byte enables, read-before-write, one-cycle read latency
  logic [31:0] bram [0:1023] = '{default: 32'h0};
  int          wr_count = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.bram_we[i]) bram[bus.bram_addr][8*i +: 8] <= bus.bram_din[8*i +: 8];
    if (|bus.bram_we) wr_count <= wr_count + 1;
    bus.bram_dout <= bram[bus.bram_addr];
  end

  // Reference state
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [31:0] rd_model;
  logic [7:0]  led_model;
  int          n_assert;
  int          n_fail;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b001:  return 1;
      3'b011:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
    longint v;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // One pipeline request, held until the controller releases it; checks timing,
  // write enables, write count, misaligned pulse, load data and the LED register.
  task automatic run_op(input string tag, input bit st, input bit ld, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    int          n, cycles, exp_cycles, wc0;
    bit          mis, oor, led_hit;
    logic [3:0]  exp_we, we_seen;
    logic        mis_seen;
    logic [31:0] exp_rd;

    n       = nbytes(m[2:0]);
    mis     = (a % n) != 0;
    oor     = a >= MEM_BYTES;
    led_hit = LED_EN && (a == LED_ADDR);
    exp_rd  = rd_model;
    exp_we  = 4'h0;
    if (mis) exp_cycles = 1;
    else if (st && led_hit) exp_cycles = 1;
    else if (st) begin
      exp_cycles = 3;
      if (!oor) exp_we = 4'(((1 << n) - 1) << (a % 4));
    end else begin
      exp_cycles = 4;
      exp_rd = led_hit ? {24'h0, led_model} : (oor ? 32'h0 : ref_load(a, n, m[3]));
    end

    @(negedge clk);
    wc0           = wr_count;
    bus.memwrite  = st;
    bus.memread   = ld;
    bus.addr      = a;
    bus.wr_data   = d;
    bus.sign_mask = m;
    #1;
    chk({tag, ".led"}, {24'h0, led}, {24'h0, led_model});
    mis_seen = bus.misaligned;
    we_seen  = 4'h0;
    cycles   = 1;
    while (bus.clk_stall && cycles < 16) begin
      we_seen |= bus.bram_we;
      @(negedge clk);
      #1;
      cycles++;
    end
    we_seen |= bus.bram_we;

    chk({tag, ".cycles"}, cycles, exp_cycles);
    chk({tag, ".misaligned"}, {31'h0, mis_seen}, {31'h0, mis});
    chk({tag, ".bram_we"}, {28'h0, we_seen}, {28'h0, exp_we});
    chk({tag, ".writes"}, wr_count - wc0, (exp_we != 0) ? 1 : 0);
    chk({tag, ".rd_data"}, bus.rd_data, exp_rd);

    if (st && !mis && led_hit) led_model = d[7:0];
    if (st && !mis && !oor && !led_hit)
      for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
    rd_model = exp_rd;
  endtask

  initial begin
    int          wc0;
    int          sz, sel;
    bit          st, ld, sgn;
    logic [31:0] a, d;
    logic [2:0]  szm;

    n_assert = 0;
    n_fail   = 0;
    rd_model = 32'h0;
    led_model = 8'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h0;

    rst           = 1'b1;
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.addr      = 32'h0;
    bus.wr_data   = 32'h0;
    bus.sign_mask = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.rd_data", bus.rd_data, 32'h0);
    chk("rst.clk_stall", {31'h0, bus.clk_stall}, 32'h0);
    chk("rst.misaligned", {31'h0, bus.misaligned}, 32'h0);
    chk("rst.led", {24'h0, led}, 32'h0);
    chk("rst.bram_we", {28'h0, bus.bram_we}, 32'h0);
    chk("rst.bram_addr", {22'h0, bus.bram_addr}, 32'h0);
    rst = 1'b0;

    // Word store then word load, back to back
    run_op("sw_10", 1, 0, 32'h10, 32'hDEAD_BEEF, 4'b0111);
    run_op("lw_10", 0, 1, 32'h10, 32'h0, 4'b1111);
    // Byte store to the top lane, signed and unsigned byte loads
    run_op("sb_13", 1, 0, 32'h13, 32'h0000_0080, 4'b0001);
    run_op("lb_13", 0, 1, 32'h13, 32'h0, 4'b1001);
    run_op("lbu_13", 0, 1, 32'h13, 32'h0, 4'b0001);
    // Misaligned half load and word store
    run_op("lh_11", 0, 1, 32'h11, 32'h0, 4'b1011);
    run_op("sw_12", 1, 0, 32'h12, 32'h1234_5678, 4'b0111);
    // Half stores/loads, both memwrite and memread high means store
    run_op("sh_1a", 1, 1, 32'h1A, 32'h0000_8001, 4'b0011);
    run_op("lh_1a", 0, 1, 32'h1A, 32'h0, 4'b1011);
    run_op("lhu_1a", 0, 1, 32'h1A, 32'h0, 4'b0011);
    // Out-of-range store suppressed, load returns zero
    run_op("sw_oor", 1, 0, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0111);
    run_op("lw_oor", 0, 1, 32'h0000_1000, 32'h0, 4'b1111);

    // Reset while the load sits in WAIT
    @(negedge clk);
    bus.memwrite = 1'b0; bus.memread = 1'b1; bus.addr = 32'h10; bus.sign_mask = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.memread = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wait.clk_stall", {31'h0, bus.clk_stall}, 32'h0);
    chk("rst_wait.rd_data", bus.rd_data, 32'h0);
    rd_model = 32'h0;
    rst = 1'b0;

    // Reset while the store sits in ISSUE
    @(negedge clk);
    wc0 = wr_count;
    bus.memwrite = 1'b1; bus.memread = 1'b0; bus.addr = 32'h20;
    bus.wr_data = 32'hCAFE_F00D; bus.sign_mask = 4'b0111;
    @(negedge clk);
    rst = 1'b1; bus.memwrite = 1'b0;
    #1;
    chk("rst_issue.bram_we", {28'h0, bus.bram_we}, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_issue.clk_stall", {31'h0, bus.clk_stall}, 32'h0);
    chk("rst_issue.mem_word", bram[8], ref_word(8));
    chk("rst_issue.writes", wr_count - wc0, 32'h0);
    rst = 1'b0;

    run_op("lw_10b", 0, 1, 32'h10, 32'h0, 4'b1111);
    run_op("lw_20", 0, 1, 32'h20, 32'h0, 4'b1111);

    // LED register: MMIO when enabled, ordinary (out-of-range) memory otherwise
    run_op("sb_led", 1, 0, LED_ADDR, 32'h0000_00A5, 4'b0001);
    run_op("lw_led", 0, 1, LED_ADDR, 32'h0, 4'b1111);

    for (int i = 0; i < 80; i++) begin
      sz  = $urandom_range(0, 2);
      szm = (sz == 0) ? 3'b001 : (sz == 1) ? 3'b011 : 3'b111;
      sgn = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 8) begin
        a = 32'($urandom_range(0, 63));
        if (sel < 6) a = a & ~32'(nbytes(szm) - 1);
      end else if (sel == 8) begin
        a = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
      end else begin
        a = 32'hFFFF_FF00;
      end
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = $urandom;
      run_op($sformatf("rnd%0d", i), st, ld, a, d, {sgn, szm});
    end

    @(negedge clk);
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
    @(negedge clk);
    #1;
    chk("end.led", {24'h0, led}, {24'h0, led_model});
    chk("end.clk_stall", {31'h0, bus.clk_stall}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
